cpu_multicycle: RTL and testbench

//  Multi-cycle WISC-16 core: FETCH/DECODE/EXEC/MEM/WB FSM over one unified memory port with
//  a req/ready handshake, so instruction and data memory can have arbitrary, variable latency.

---
 rtl/cpu_multicycle.sv | 176 +++++++++++++++++
 tb/tb_cpu_multicycle.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// Multi-cycle WISC-16 core over one unified req/ready memory port; stalls on memory.
// Memory outputs decode from state/pc/address registers, so they hold steady while stalled.
module cpu_multicycle #(
  parameter int                ADDR_W   = 16,
  parameter int                NREGS    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              hlt,
  output logic [CNT_W-1:0]  retired
);
  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [3:0] OP_LW = 4'h8, OP_SW = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB,
                         OP_B = 4'hC, OP_BR = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t            state, nxt;
  logic [15:0]       ir, a_q, b_q, c_q, res_q;
  logic [15:0]       rf [NREGS];
  logic              flag_z, flag_v, flag_n;
  logic [ADDR_W-1:0] maddr_q, pc2, br_tgt;
  logic [3:0]        op;
  logic [RW-1:0]     rd_i, rs_i, rt_i;
  logic [15:0]       sum, dif, alu_res, boff, ea;
  logic [9:0]        red;
  logic [4:0]        nib;
  logic              alu_ovf, take, retire;

  assign op     = ir[15:12];
  assign rd_i   = RW'(ir[11:8]);
  assign rs_i   = RW'(ir[7:4]);
  assign rt_i   = RW'(ir[3:0]);
  assign pc2    = pc + ADDR_W'(2);
  assign boff   = {{6{ir[8]}}, ir[8:0], 1'b0};
  assign br_tgt = pc2 + boff[ADDR_W-1:0];
  assign ea     = (a_q & 16'hFFFE) + {{11{ir[3]}}, ir[3:0], 1'b0};

  assign mem_req   = !rst && (state == FETCH || state == MEM);
  assign mem_we    = !rst && state == MEM && op == OP_SW;
  assign mem_addr  = (state == MEM) ? maddr_q : {pc[ADDR_W-1:1], 1'b0};
  assign mem_wdata = c_q;
  assign hlt       = (state == HALT);
  assign retire    = (nxt == FETCH && (state == EXEC || state == MEM || state == WB)) ||
                     (nxt == HALT && state == DECODE);

  always_comb begin
    sum     = a_q + b_q;
    dif     = a_q - b_q;
    red     = {{2{a_q[15]}}, a_q[15:8]} + {{2{b_q[15]}}, b_q[15:8]}
            + {{2{a_q[7]}}, a_q[7:0]} + {{2{b_q[7]}}, b_q[7:0]};
    nib     = '0;
    alu_ovf = 1'b0;
    alu_res = '0;
    case (ir[14:12])
      3'd0: begin
        alu_ovf = (a_q[15] == b_q[15]) && (sum[15] != a_q[15]);
        alu_res = alu_ovf ? {a_q[15], {15{~a_q[15]}}} : sum;
      end
      3'd1: begin
        alu_ovf = (a_q[15] != b_q[15]) && (dif[15] != a_q[15]);
        alu_res = alu_ovf ? {a_q[15], {15{~a_q[15]}}} : dif;
      end
      3'd2: alu_res = a_q ^ b_q;
      3'd3: alu_res = {{6{red[9]}}, red};
      3'd4: alu_res = a_q << ir[3:0];
      3'd5: alu_res = $signed(a_q) >>> ir[3:0];
      3'd6: alu_res = (a_q >> ir[3:0]) | (a_q << (5'd16 - {1'b0, ir[3:0]}));
      default: begin
        // four independent saturating signed nibble adds
        for (int i = 0; i < 4; i++) begin
          nib = {a_q[4*i+3], a_q[4*i +: 4]} + {b_q[4*i+3], b_q[4*i +: 4]};
          alu_res[4*i +: 4] = (nib[4] != nib[3]) ? {nib[4], {3{~nib[4]}}} : nib[3:0];
        end
      end
    endcase
  end

  always_comb begin
    case (ir[11:9])
      3'd0:    take = !flag_z;
      3'd1:    take = flag_z;
      3'd2:    take = !flag_z && !flag_n;
      3'd3:    take = flag_n;
      3'd4:    take = flag_z || (!flag_z && !flag_n);
      3'd5:    take = flag_n || flag_z;
      3'd6:    take = flag_v;
      default: take = 1'b1;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      FETCH:   if (mem_ready) nxt = DECODE;
      DECODE:  nxt = (op == OP_HLT) ? HALT : EXEC;
      EXEC: begin
        if (op == OP_LW || op == OP_SW)     nxt = MEM;
        else if (op == OP_B || op == OP_BR) nxt = FETCH;
        else                                nxt = WB;
      end
      MEM:     if (mem_ready) nxt = (op == OP_LW) ? WB : FETCH;
      WB:      nxt = FETCH;
      HALT:    nxt = HALT;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      maddr_q <= '0;
      flag_z  <= 1'b0;
      flag_v  <= 1'b0;
      flag_n  <= 1'b0;
      retired <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      if (retire) retired <= retired + CNT_W'(1);
      case (state)
        FETCH:  if (mem_ready) ir <= mem_rdata;
        DECODE: begin
          a_q <= rf[rs_i];
          b_q <= rf[rt_i];
          c_q <= rf[rd_i];
        end
        EXEC: begin
          res_q <= alu_res;
          case (op)
            OP_LW, OP_SW: maddr_q <= ea[ADDR_W-1:0];
            OP_LLB:       res_q <= {c_q[15:8], ir[7:0]};
            OP_LHB:       res_q <= {ir[7:0], c_q[7:0]};
            OP_PCS:       res_q <= 16'(pc2);
            OP_B:         pc <= take ? br_tgt : pc2;
            OP_BR:        pc <= take ? (a_q[ADDR_W-1:0] & ~ADDR_W'(1)) : pc2;
            default: ;
          endcase
          // RED and PADDSB (ops 3 and 7) leave every flag alone
          if (!op[3] && op[1:0] != 2'b11) flag_z <= (alu_res == 16'h0000);
          if (op[3:1] == 3'b000) begin
            flag_v <= alu_ovf;
            flag_n <= alu_res[15];
          end
        end
        MEM: if (mem_ready) begin
          if (op == OP_LW) res_q <= mem_rdata;
          else             pc    <= pc2;
        end
        WB: begin
          if (rd_i != '0) rf[rd_i] <= res_q;
          pc <= pc2;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: ALU vector table plus multi-cycle sequences
// (wait states, branches, store/load, reset mid-request, narrow address/register config).
`timescale 1ns/1ps
module tb_cpu_multicycle;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, rst8 = 1'b1;
  logic        mem_req, mem_we, mem_ready, hlt;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [31:0] retired;
  logic        mem_req8, mem_we8, mem_ready8, hlt8;
  logic [7:0]  mem_addr8, pc8;
  logic [15:0] mem_wdata8, mem_rdata8;
  logic [31:0] retired8;

  cpu_multicycle dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .hlt(hlt), .retired(retired));

  cpu_multicycle #(.ADDR_W(8), .NREGS(8), .RESET_PC(8'hFC), .CNT_W(32)) dut8 (
    .clk(clk), .rst(rst8), .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr(mem_addr8),
    .mem_wdata(mem_wdata8), .mem_rdata(mem_rdata8), .mem_ready(mem_ready8),
    .pc(pc8), .hlt(hlt8), .retired(retired8));

  // Memory for the 16-bit core: program image plus a store overlay cleared on reset.
  logic [15:0] prog [256];
  logic [15:0] dmem [256];
  logic        dvld [256];
  int          wait_n = 0, wcnt = 0, st_cnt = 0;
  logic [15:0] st_addr = '0, st_data = '0;
  logic [7:0]  midx;
  assign midx      = mem_addr[8:1];
  assign mem_rdata = dvld[midx] ? dmem[midx] : prog[midx];
  assign mem_ready = mem_req && (wcnt >= wait_n);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) dvld[i] <= 1'b0;
    end else if (mem_req && mem_ready && mem_we) begin
      dmem[midx] <= mem_wdata;
      dvld[midx] <= 1'b1;
      st_addr    <= mem_addr;
      st_data    <= mem_wdata;
      st_cnt     <= st_cnt + 1;
    end
    wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
  end

  // Request stability while stalled, and count of stall cycles.
  logic        p_req = 1'b0, p_rdy = 1'b0, p_we = 1'b0;
  logic [15:0] p_addr = '0, p_wd = '0;
  int          stab_err = 0, stall_cnt = 0;
  always @(negedge clk) begin
    if (!rst && p_req && !p_rdy &&
        (!mem_req || mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wd))
      stab_err <= stab_err + 1;
    if (mem_req && !mem_ready) stall_cnt <= stall_cnt + 1;
    p_req  <= mem_req;
    p_rdy  <= mem_ready;
    p_we   <= mem_we;
    p_addr <= mem_addr;
    p_wd   <= mem_wdata;
  end

  // Zero-wait memory for the narrow core.
  logic [15:0] prog8 [128];
  logic [7:0]  f8_last = 8'hAA;
  logic [15:0] wd8_seen = '0;
  int          st8_cnt = 0;
  assign mem_rdata8 = prog8[mem_addr8[7:1]];
  assign mem_ready8 = mem_req8;
  always @(posedge clk) begin
    if (mem_req8 && mem_ready8 && !mem_we8) f8_last <= mem_addr8;
    if (mem_req8 && mem_we8) begin
      st8_cnt  <= st8_cnt + 1;
      wd8_seen <= mem_wdata8;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // n = cycles from the first edge with rst low to the edge that raises hlt.
  task automatic run_to_halt(input int budget, output int n);
    n = 0;
    @(posedge clk); #1;
    while (!hlt && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!hlt) begin
      checks++;
      errors++;
      $display("FAIL halt_timeout: got hlt=0 expected hlt=1 within %0d cycles", budget);
    end
  endtask

  typedef struct {
    logic [15:0] a, b, instr, res;
    logic [2:0]  zvn;
  } vec_t;

  initial begin
    vec_t vt [12];
    int   n, s0, e0, c0;

    //        a         b         instr     result    {Z,V,N}
    vt[0]  = '{16'h0005, 16'h0003, 16'h0312, 16'h0008, 3'b000};  // ADD
    vt[1]  = '{16'h7FFF, 16'h0001, 16'h0312, 16'h7FFF, 3'b010};  // ADD +sat
    vt[2]  = '{16'h0004, 16'h0004, 16'h1312, 16'h0000, 3'b100};  // SUB zero
    vt[3]  = '{16'h8000, 16'h0001, 16'h1312, 16'h8000, 3'b011};  // SUB -sat
    vt[4]  = '{16'hF0F0, 16'hFFFF, 16'h2312, 16'h0F0F, 3'b000};  // XOR
    vt[5]  = '{16'h1234, 16'h0000, 16'h4314, 16'h2340, 3'b000};  // SLL 4
    vt[6]  = '{16'h8000, 16'h0000, 16'h531F, 16'hFFFF, 3'b000};  // SRA 15
    vt[7]  = '{16'h0001, 16'h0000, 16'h6311, 16'h8000, 3'b000};  // ROR 1
    vt[8]  = '{16'h8000, 16'h0000, 16'h4311, 16'h0000, 3'b100};  // SLL to zero
    vt[9]  = '{16'h0102, 16'h0304, 16'h3312, 16'h000A, 3'b000};  // RED
    vt[10] = '{16'h7823, 16'h1811, 16'h7312, 16'h7834, 3'b000};  // PADDSB sat both ways
    vt[11] = '{16'hFFFF, 16'hFFFF, 16'h0312, 16'hFFFE, 3'b001};  // ADD negative

    for (int i = 0; i < 128; i++) prog8[i] = 16'hF000;

    for (int k = 0; k < 12; k++) begin
      clear_prog();
      prog[0] = {8'hA1, vt[k].a[7:0]};
      prog[1] = {8'hB1, vt[k].a[15:8]};
      prog[2] = {8'hA2, vt[k].b[7:0]};
      prog[3] = {8'hB2, vt[k].b[15:8]};
      prog[4] = vt[k].instr;
      wait_n = 0;
      do_reset();
      run_to_halt(100, n);
      chk($sformatf("vec%0d_result", k), 32'(dut.rf[3]), 32'(vt[k].res));
      chk($sformatf("vec%0d_flags_zvn", k), 32'({dut.flag_z, dut.flag_v, dut.flag_n}), 32'(vt[k].zvn));
    end

    // Basic program, zero-wait memory.
    clear_prog();
    prog[0] = 16'hA105; prog[1] = 16'hA203; prog[2] = 16'h0312;
    wait_n = 0;
    do_reset();
    run_to_halt(100, n);
    chk("t1_cycles", 32'(n), 32'd13);
    chk("t1_r3", 32'(dut.rf[3]), 32'h0008);
    chk("t1_z", 32'(dut.flag_z), 32'd0);
    chk("t1_hlt", 32'(hlt), 32'd1);
    chk("t1_retired", retired, 32'd4);

    // Same program, three wait cycles per request.
    wait_n = 3;
    s0 = stall_cnt; e0 = stab_err;
    do_reset();
    run_to_halt(300, n);
    chk("t2_stable", 32'(stab_err - e0), 32'd0);
    chk("t2_stalls", 32'(stall_cnt - s0), 32'd12);
    chk("t2_cycles", 32'(n), 32'd25);
    chk("t2_r3", 32'(dut.rf[3]), 32'h0008);
    chk("t2_z", 32'(dut.flag_z), 32'd0);
    chk("t2_retired", retired, 32'd4);

    // Branch taken on Z=1, skipping two instructions.
    clear_prog();
    prog[0] = 16'h1111; prog[1] = 16'hC202; prog[2] = 16'hA7AA;
    wait_n = 0;
    do_reset();
    run_to_halt(100, n);
    chk("t3_taken_cycles", 32'(n), 32'd8);
    chk("t3_taken_z", 32'(dut.flag_z), 32'd1);
    chk("t3_taken_pc", 32'(pc), 32'h0008);
    chk("t3_taken_r7", 32'(dut.rf[7]), 32'h0000);
    chk("t3_taken_retired", retired, 32'd3);

    // Same, condition Z=0: falls through.
    prog[1] = 16'hC002;
    do_reset();
    run_to_halt(100, n);
    chk("t3_fall_pc", 32'(pc), 32'h0006);
    chk("t3_fall_r7", 32'(dut.rf[7]), 32'h00AA);
    chk("t3_fall_retired", retired, 32'd4);

    // Store to an odd base plus offset, then load it back.
    clear_prog();
    prog[0] = 16'h1111; prog[1] = 16'hA5EF; prog[2] = 16'hB5BE;
    prog[3] = 16'hA411; prog[4] = 16'h9541; prog[5] = 16'h8641;
    c0 = st_cnt;
    do_reset();
    run_to_halt(200, n);
    chk("t4_store_count", 32'(st_cnt - c0), 32'd1);
    chk("t4_store_addr", 32'(st_addr), 32'h0012);
    chk("t4_store_data", 32'(st_data), 32'hBEEF);
    chk("t4_r6", 32'(dut.rf[6]), 32'hBEEF);
    chk("t4_flags_zvn", 32'({dut.flag_z, dut.flag_v, dut.flag_n}), 32'b100);

    // Reset while a load is stalled in its data access.
    clear_prog();
    prog[0] = 16'hA410; prog[1] = 16'h8640; prog[8] = 16'h1234;
    wait_n = 6;
    do_reset();
    n = 0;
    while (!(mem_req && mem_addr == 16'h0010) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_reached_mem", 32'(mem_req && mem_addr == 16'h0010), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    prog[0] = 16'hF000;
    wait_n = 0;
    @(posedge clk); #1;
    chk("t5_rst_req", 32'(mem_req), 32'd0);
    chk("t5_rst_pc", 32'(pc), 32'h0000);
    chk("t5_rst_retired", retired, 32'd0);
    chk("t5_rst_hlt", 32'(hlt), 32'd0);
    rst = 1'b0;
    #1;
    chk("t5_fetch_req", 32'(mem_req), 32'd1);
    chk("t5_fetch_we", 32'(mem_we), 32'd0);
    chk("t5_fetch_addr", 32'(mem_addr), 32'h0000);
    run_to_halt(100, n);
    chk("t5_r6", 32'(dut.rf[6]), 32'h0000);
    chk("t5_r4", 32'(dut.rf[4]), 32'h0000);
    chk("t5_retired", retired, 32'd1);

    // Narrow core: PC wrap past 0xFE and register index folding.
    prog8[7'h7E] = 16'hAA21;
    prog8[7'h7F] = 16'h09AA;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    n = 0;
    while (!hlt8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_hlt", 32'(hlt8), 32'd1);
    chk("t6_wrap_fetch", 32'(f8_last), 32'h00);
    chk("t6_pc", 32'(pc8), 32'h00);
    chk("t6_r1", 32'(dut8.rf[1]), 32'h0042);
    chk("t6_r2", 32'(dut8.rf[2]), 32'h0021);
    chk("t6_retired", retired8, 32'd3);
    chk("t6_no_store", {st8_cnt[15:0], wd8_seen}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
